frame_draw_scheduler: RTL
=========================

// Module: frame_draw_scheduler
// PURPOSE
// - Sequences one frame into the double-buffered VGA memory. Optionally clears the back buffer,
//   then shares its single write port among N_REQ pixel-drawing engines (OnePixel-style) by
//   round-robin arbitration, then requests the buffer swap.
// - Sits between the drawing engines and vga_driver_memory_double_buf. Its wr_* outputs drive
//   external_address/external_data, and buf_swap drives external_start.
// PARAMETERS
// - N_REQ        4          number of drawing requesters
// - ADDR_W       15         frame-buffer word address width
// - DATA_W       24         pixel colour width (RGB888)
// - FB_WORDS     19200      valid buffer words (160x120); addresses >= FB_WORDS are out of range
// - CLEAR_COLOR  24'h000000 colour written during the clear pass
// PORTS
// - clk        in   1             system clock (CLOCK_50)
// - rst        in   1             synchronous reset, active-high
// - frame_go   in   1             pulse: start a frame; ignored while busy=1
// - clear_en   in   1             sampled on the accepted frame_go; 1 = run the clear pass
// - req        in   N_REQ         per-requester write request, held until granted
// - req_addr   in   N_REQ*ADDR_W  flat; requester i occupies [i*ADDR_W +: ADDR_W]
// - req_data   in   N_REQ*DATA_W  flat; requester i occupies [i*DATA_W +: DATA_W]
// - req_done   in   N_REQ         level/pulse: requester i has finished drawing this frame
// - swap_ack   in   1             memory module has swapped buffers
// - draw_start out  1             1-cycle pulse on entering DRAW
// - grant      out  N_REQ         one-hot; bit i = requester i's data was written this cycle
// - wr_en      out  1             write strobe to the frame buffer
// - wr_addr    out  ADDR_W        write address
// - wr_data    out  DATA_W        write data
// - buf_swap   out  1             swap request (external_start); held until swap_ack
// - busy       out  1             1 in every state except IDLE
// - frame_done out  1             1-cycle pulse when the swap completes
// - oob_drop   out  1             1-cycle pulse: a granted write was out of range and suppressed
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, RR pointer = 0, done mask = 0, clear counter = 0.
//   Reset mid-frame aborts immediately. No partial write or swap follows.
// - All outputs are registered.
// - IDLE: frame_go -> CLEAR if clear_en = 1, else DRAW. The done mask is cleared on frame_go.
// - CLEAR:
//   - wr_en = 1 every cycle, wr_data = CLEAR_COLOR, wr_addr = 0 .. FB_WORDS-1, one address per cycle.
//   - grant = 0 and req is ignored.
//   - After the write to FB_WORDS-1, go to DRAW. A clear takes exactly FB_WORDS cycles.
// - DRAW: draw_start pulses in the first DRAW cycle.
//   - req_done[i] sets sticky mask bit i. Masked requesters are never granted.
//   - Arbitration on edge t: eligible = req & ~mask & ~grant_q, where grant_q is the grant
//     currently being output. This prevents re-granting stale data. A lone requester therefore
//     gets at most one write every 2 cycles.
//   - Winner = first eligible index at or after the RR pointer, wrapping modulo N_REQ.
//   - In cycle t+1: grant[w] = 1, wr_addr/wr_data = the values captured at edge t, and
//     wr_en = 1 only if addr < FB_WORDS; otherwise wr_en = 0 and oob_drop = 1.
//     The RR pointer moves to w+1 mod N_REQ.
//   - The requester advances to its next pixel on seeing grant.
//   - If req_done[i] and req[i] are both high in the same cycle, that last request is still
//     served before the mask takes effect.
//   - Exit to SWAP when mask == all-ones, no request is eligible, and no grant is outstanding.
// - SWAP:
//   - buf_swap = 1 and wr_en = 0 until swap_ack = 1.
//   - On the cycle after swap_ack: buf_swap = 0, frame_done = 1, state IDLE.
//   - swap_ack seen outside SWAP is ignored.
// - frame_go while busy is dropped and not queued.
// - States encode into 2 bits: IDLE = 0, CLEAR = 1, DRAW = 2, SWAP = 3.
// STRUCTURE
// - Shared package/header (fb_pkg): state encodings, FB_WORDS, ADDR_W, DATA_W, CLEAR_COLOR.
// - Sub-module fb_rr_arbiter (N_REQ param): inputs eligible and pointer; outputs a one-hot
//   winner and a valid flag. Purely combinational.
// - The FSM, clear counter, done mask, and output registers live in the top.
// TESTING
// - Reset and clear:
//   - Assert rst for 2 cycles -> all outputs 0.
//   - frame_go with clear_en = 1 -> exactly 19200 consecutive wr_en cycles, addr 0..19199,
//     data 24'h000000.
//   - Then draw_start pulses once.
// - Single requester:
//   - req[0] held with addr 400, data 24'hFF0000 -> grant[0] and a write at addr 400,
//     1 cycle after sampling.
//   - With req held continuously, writes occur every 2nd cycle.
// - Round robin:
//   - All 4 req held -> grant order 0,1,2,3,0,...
//   - No requester is granted twice before each other eligible requester has been granted once.
// - Out of range:
//   - req[2] with addr 19200 -> grant[2] = 1, wr_en = 0, oob_drop = 1 for exactly 1 cycle.
// - Completion and swap:
//   - req_done for all 4 -> buf_swap rises.
//   - Hold swap_ack low 10 cycles -> buf_swap stays 1.
//   - Then pulse swap_ack -> frame_done pulses once, busy = 0.
// - Robustness:
//   - frame_go during DRAW is ignored.
//   - rst asserted mid-CLEAR -> next cycle IDLE with wr_en = 0.
//   - After rst, frame_go with clear_en = 0 goes straight to DRAW.

Source files
------------

// File: rtl/frame_draw_scheduler_pkg.sv
// Shared constants and types for the frame draw scheduler.
package frame_draw_scheduler_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned FB_WORDS = 19200;

  localparam logic [DATA_W-1:0] CLEAR_COLOR = 24'h000000;
  localparam logic [ADDR_W-1:0] FB_WORDS_A  = ADDR_W'(FB_WORDS);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDraw  = 2'd2,
    StSwap  = 2'd3
  } fds_state_e;

  // True when a word address lies inside the visible frame buffer.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < FB_WORDS_A;
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
module frame_draw_scheduler_rr_arbiter #(
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned PtrW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [PtrW-1:0]  pointer_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             valid_o
);

  // Scan from the pointer, wrapping, and keep only the first hit.
  always_comb begin
    logic [PtrW-1:0] idx;
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PtrW'((32'(pointer_i) + k) % N_REQ);
      if (!valid_o && eligible_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Frame sequencer: optional back-buffer clear, round-robin pixel writes, then buffer swap.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_go,
  input  logic                    clear_en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_done,
  input  logic                    swap_ack,
  output logic                    draw_start,
  output logic [N_REQ-1:0]        grant,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    buf_swap,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    oob_drop
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  fds_state_e        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              draw_start_q, draw_start_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              buf_swap_q, buf_swap_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              oob_drop_q, oob_drop_d;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  winner;
  logic              win_valid;
  logic [PtrW-1:0]   win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // The requester currently shown a grant still holds the data just written.
  assign eligible = req & ~mask_q & ~grant_q;

  frame_draw_scheduler_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .eligible_i (eligible),
    .pointer_i  (ptr_q),
    .winner_o   (winner),
    .valid_o    (win_valid)
  );

  // Encode the one-hot winner and select its address and data.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_idx  = PtrW'(i);
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mask_d       = mask_q;
    clr_cnt_d    = clr_cnt_q;
    draw_start_d = 1'b0;
    grant_d      = '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    buf_swap_d   = 1'b0;
    frame_done_d = 1'b0;
    oob_drop_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_go) begin
          mask_d = '0;
          if (clear_en) begin
            // First clear write leaves on the same edge the frame is accepted.
            state_d   = StClear;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = CLEAR_COLOR;
            clr_cnt_d = ADDR_W'(1);
          end else begin
            state_d      = StDraw;
            draw_start_d = 1'b1;
          end
        end
      end
      StClear: begin
        if (clr_cnt_q != FB_WORDS_A) begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q;
          wr_data_d = CLEAR_COLOR;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end else begin
          state_d      = StDraw;
          draw_start_d = 1'b1;
          clr_cnt_d    = '0;
        end
      end
      StDraw: begin
        // Eligibility uses the old mask so a request paired with its done is still served.
        mask_d = mask_q | req_done;
        if (win_valid) begin
          grant_d    = winner;
          wr_addr_d  = win_addr;
          wr_data_d  = win_data;
          wr_en_d    = addr_in_range(win_addr);
          oob_drop_d = !addr_in_range(win_addr);
          ptr_d      = (win_idx == PtrW'(N_REQ - 1)) ? '0 : win_idx + PtrW'(1);
        end else if ((&mask_q) && (grant_q == '0)) begin
          state_d    = StSwap;
          buf_swap_d = 1'b1;
        end
      end
      StSwap: begin
        if (swap_ack) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end else begin
          buf_swap_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      mask_q       <= '0;
      clr_cnt_q    <= '0;
      draw_start_q <= 1'b0;
      grant_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      buf_swap_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      oob_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mask_q       <= mask_d;
      clr_cnt_q    <= clr_cnt_d;
      draw_start_q <= draw_start_d;
      grant_q      <= grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      buf_swap_q   <= buf_swap_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      oob_drop_q   <= oob_drop_d;
    end
  end

  assign draw_start = draw_start_q;
  assign grant      = grant_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign buf_swap   = buf_swap_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign oob_drop   = oob_drop_q;

endmodule
